// File: rtl/constraint_sample_sequencer.sv
// constraint_sample_sequencer
//   Feeds pseudo-random candidates from a Galois LFSR into an external
//   combinational constraint checker, waits CHECK_LAT cycles for the verdict,
//   and streams every satisfying candidate out over a valid/ready handshake
//   until req_count samples have been delivered or a sample exhausts its
//   MAX_TRIES budget.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, abort        run control (start only honoured in IDLE)
//   seed_load, seed     LFSR seed load (only honoured in IDLE; zero loads as 1)
//   req_count           number of satisfying samples wanted, latched at start
//   cand_o, sat_i       registered candidate to the checker, checker verdict
//   sample_valid/ready  output handshake, sample_data holds the candidate
//   busy, done, fail    status; done/fail are single-cycle pulses
//   tries               candidates tried for the current/last sample
module constraint_sample_sequencer #(
  parameter int unsigned       CAND_W    = 64,
  parameter logic [CAND_W-1:0] POLY      = 64'hD800_0000_0000_0000,
  parameter int unsigned       CHECK_LAT = 1,
  parameter int unsigned       MAX_TRIES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [CAND_W-1:0] seed,
  input  logic [15:0]       req_count,
  output logic [CAND_W-1:0] cand_o,
  input  logic              sat_i,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CAND_W-1:0] sample_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       tries
);

  localparam int unsigned WCW = (CHECK_LAT < 2) ? 1 : $clog2(CHECK_LAT + 1);
  localparam logic [CAND_W-1:0] LFSR_ONE = {{(CAND_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CAND_W-1:0] lfsr_q, lfsr_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [CAND_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [15:0]       tries_q, tries_d;
  logic [15:0]       rem_q, rem_d;
  logic [WCW-1:0]    wait_q, wait_d;

  logic [CAND_W-1:0] lfsr_nxt;
  logic [15:0]       tries_inc;

  always_comb begin
    lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    tries_inc = (tries_q == '1) ? tries_q : tries_q + 16'd1;

    state_d = state_q;
    lfsr_d  = lfsr_q;
    cand_d  = cand_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    tries_d = tries_q;
    rem_d   = rem_q;
    wait_d  = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        // Seed is applied before start so a same-cycle start draws from it.
        if (seed_load) begin
          lfsr_d = (seed == '0) ? LFSR_ONE : seed;
        end
        if (start) begin
          rem_d   = req_count;
          tries_d = '0;
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        lfsr_d  = lfsr_nxt;
        cand_d  = lfsr_nxt;
        tries_d = tries_inc;
        wait_d  = WCW'(CHECK_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WCW'(1)) begin
          if (sat_i) begin
            data_d  = cand_q;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else if (tries_q == 16'(MAX_TRIES)) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAW;
          end
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      ST_HOLD: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tries_d = '0;
            state_d = ST_DRAW;
          end
        end
      end
    endcase

    // Abort overrides every state action above, including a same-cycle
    // handshake or draw; LFSR and candidate are left where they were.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      lfsr_d  = lfsr_q;
      cand_d  = cand_q;
      data_d  = data_q;
      valid_d = 1'b0;
      tries_d = tries_q;
      rem_d   = rem_q;
      wait_d  = wait_q;
      done_d  = 1'b0;
      fail_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_ONE;
      cand_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      tries_q <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      tries_q <= tries_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
    end
  end

  assign cand_o       = cand_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign fail         = fail_q;
  assign tries        = tries_q;

endmodule

// File: tb/tb_constraint_sample_sequencer.sv
// Bench for constraint_sample_sequencer: two 8-bit instances (CHECK_LAT 1 with
// a 4-try budget, and CHECK_LAT 3), directed vectors and randomized runs.
module tb_constraint_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_abort, a_seed_load, a_sat, a_ready;
  logic        a_valid, a_busy, a_done, a_fail;
  logic [7:0]  a_seed, a_cand, a_data;
  logic [15:0] a_req, a_tries;

  logic        b_start, b_abort, b_seed_load, b_sat, b_ready;
  logic        b_valid, b_busy, b_done, b_fail;
  logic [7:0]  b_seed, b_cand, b_data;
  logic [15:0] b_req, b_tries;

  int unsigned sat_mode;
  logic [7:0]  sat_target, sat_mask;

  constraint_sample_sequencer #(
    .CAND_W(8), .POLY(8'hB8), .CHECK_LAT(1), .MAX_TRIES(4)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .seed_load(a_seed_load), .seed(a_seed), .req_count(a_req),
    .cand_o(a_cand), .sat_i(a_sat), .sample_valid(a_valid),
    .sample_ready(a_ready), .sample_data(a_data), .busy(a_busy),
    .done(a_done), .fail(a_fail), .tries(a_tries)
  );

  constraint_sample_sequencer #(
    .CAND_W(8), .POLY(8'hB8), .CHECK_LAT(3), .MAX_TRIES(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .seed_load(b_seed_load), .seed(b_seed), .req_count(b_req),
    .cand_o(b_cand), .sat_i(b_sat), .sample_valid(b_valid),
    .sample_ready(b_ready), .sample_data(b_data), .busy(b_busy),
    .done(b_done), .fail(b_fail), .tries(b_tries)
  );

  // Checker model driven from the candidate the DUT presents.
  always_comb begin
    case (sat_mode)
      0:       a_sat = 1'b0;
      1:       a_sat = 1'b1;
      2:       a_sat = (a_cand == sat_target);
      default: a_sat = ((a_cand & sat_mask) == sat_target);
    endcase
  end
  assign b_sat = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR step written arithmetically: halve, fold in 0xB8 on odd.
  function automatic logic [7:0] step(input logic [7:0] x);
    int unsigned v;
    v = int'(x) / 2;
    if (int'(x) % 2 == 1) v = v ^ 184;
    return 8'(v);
  endfunction

  function automatic logic msat(input logic [7:0] c);
    return ((c & sat_mask) == sat_target);
  endfunction

  typedef struct {
    logic        start, seed_load;
    logic [7:0]  seed;
    logic [15:0] req;
    logic        ready;
    logic [7:0]  cand;
    logic        valid;
    logic [7:0]  data;
    logic        busy, done, fail;
    logic [15:0] tries;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic st, input logic sl, input logic [7:0] sd,
                              input logic [15:0] rq, input logic rdy,
                              input logic [7:0] cd, input logic vl, input logic [7:0] dt,
                              input logic bs, input logic dn, input logic fl,
                              input logic [15:0] tr);
    vec_t v;
    v.start = st; v.seed_load = sl; v.seed = sd; v.req = rq; v.ready = rdy;
    v.cand = cd; v.valid = vl; v.data = dt; v.busy = bs; v.done = dn;
    v.fail = fl; v.tries = tr;
    tbl.push_back(v);
  endfunction

  logic [7:0] exp_draw [4];
  logic [7:0] exp_q[$], got_q[$];
  logic [7:0] m_lfsr, lf, prev, pd;
  logic [15:0] pt;
  logic pv, exp_fail, found, valid_seen;
  int t, exp_tries, done_n, fail_n, ndraw, last_c, ns;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_draw[0] = 8'hB8; exp_draw[1] = 8'h5C; exp_draw[2] = 8'h2E; exp_draw[3] = 8'h17;
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_seed_load = 0; a_seed = '0; a_req = '0; a_ready = 0;
    b_start = 0; b_abort = 0; b_seed_load = 0; b_seed = '0; b_req = '0; b_ready = 0;
    sat_mode = 2; sat_target = 8'h2E; sat_mask = 8'hFF;

    // T1 then T2 (ready withheld 5 cycles): one row per clock.
    add(0,1,8'h01,0,1, 8'h00,0,8'h00,0,0,0,0);
    add(1,0,8'h00,1,1, 8'h00,0,8'h00,1,0,0,0);
    add(0,0,8'h00,0,1, 8'hB8,0,8'h00,1,0,0,1);
    add(0,0,8'h00,0,1, 8'hB8,0,8'h00,1,0,0,1);
    add(0,0,8'h00,0,1, 8'h5C,0,8'h00,1,0,0,2);
    add(0,0,8'h00,0,1, 8'h5C,0,8'h00,1,0,0,2);
    add(0,0,8'h00,0,1, 8'h2E,0,8'h00,1,0,0,3);
    add(0,0,8'h00,0,1, 8'h2E,1,8'h2E,1,0,0,3);
    add(0,0,8'h00,0,1, 8'h2E,0,8'h2E,0,1,0,3);
    add(0,0,8'h00,0,0, 8'h2E,0,8'h2E,0,0,0,3);
    add(0,1,8'h01,0,0, 8'h2E,0,8'h2E,0,0,0,3);
    add(1,0,8'h00,1,0, 8'h2E,0,8'h2E,1,0,0,0);
    add(0,0,8'h00,0,0, 8'hB8,0,8'h2E,1,0,0,1);
    add(0,0,8'h00,0,0, 8'hB8,0,8'h2E,1,0,0,1);
    add(0,0,8'h00,0,0, 8'h5C,0,8'h2E,1,0,0,2);
    add(0,0,8'h00,0,0, 8'h5C,0,8'h2E,1,0,0,2);
    add(0,0,8'h00,0,0, 8'h2E,0,8'h2E,1,0,0,3);
    add(0,0,8'h00,0,0, 8'h2E,1,8'h2E,1,0,0,3);
    for (int i = 0; i < 5; i++) add(0,0,8'h00,0,0, 8'h2E,1,8'h2E,1,0,0,3);
    add(0,0,8'h00,0,1, 8'h2E,0,8'h2E,0,1,0,3);
    add(0,0,8'h00,0,0, 8'h2E,0,8'h2E,0,0,0,3);

    // Reset state
    tick; tick;
    chk("rst_cand", a_cand, 0);   chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);   chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);   chk("rst_fail", a_fail, 0);
    chk("rst_tries", a_tries, 0); chk("rst_b_cand", b_cand, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      a_start = tbl[i].start; a_seed_load = tbl[i].seed_load; a_seed = tbl[i].seed;
      a_req = tbl[i].req; a_ready = tbl[i].ready;
      tick;
      chk($sformatf("tbl%0d_cand", i), a_cand, tbl[i].cand);
      chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_data", i), a_data, tbl[i].data);
      chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), a_done, tbl[i].done);
      chk($sformatf("tbl%0d_fail", i), a_fail, tbl[i].fail);
      chk($sformatf("tbl%0d_tries", i), a_tries, tbl[i].tries);
    end
    a_start = 0; a_seed_load = 0; a_ready = 0;

    // T3: nothing satisfies, budget of 4 tries
    a_seed = 8'h01; a_seed_load = 1; tick; a_seed_load = 0;
    sat_mode = 0; a_req = 1; a_start = 1; tick; a_start = 0;
    ndraw = 0; prev = a_cand; last_c = 0; valid_seen = 0; fail_n = 0; done_n = 0;
    for (int c = 1; c < 40 && fail_n == 0; c++) begin
      tick;
      if (a_valid) valid_seen = 1;
      if (a_cand !== prev) begin
        if (ndraw < 4) chk($sformatf("t3_draw%0d", ndraw), a_cand, exp_draw[ndraw]);
        if (ndraw > 0) chk("t3_gap", c - last_c, 2);
        ndraw++; last_c = c; prev = a_cand;
      end
      if (a_fail) fail_n++;
      if (a_done) done_n++;
    end
    chk("t3_ndraw", ndraw, 4);  chk("t3_fail", fail_n, 1);
    chk("t3_done", done_n, 0);  chk("t3_tries", a_tries, 4);
    chk("t3_valid", valid_seen, 0); chk("t3_busy", a_busy, 0);

    // T5: zero seed loads as 1; req=0 completes immediately
    a_seed = 8'h00; a_seed_load = 1; tick; a_seed_load = 0;
    a_req = 0; a_start = 1; tick; a_start = 0;
    chk("t5_done", a_done, 1); chk("t5_busy", a_busy, 0); chk("t5_tries", a_tries, 0);
    chk("t5_nodraw", a_cand, 8'h17);
    tick;
    chk("t5_done_clr", a_done, 0);
    sat_mode = 1; a_req = 1; a_start = 1; tick; a_start = 0; tick;
    chk("t5_first", a_cand, 8'hB8);
    tick; a_ready = 1; tick; a_ready = 0;
    chk("t5_run_done", a_done, 1);

    // T6a: abort in WAIT
    sat_mode = 0; a_req = 1; a_start = 1; tick; a_start = 0; tick;
    chk("t6a_cand", a_cand, 8'h5C);
    a_abort = 1; tick; a_abort = 0;
    chk("t6a_busy", a_busy, 0); chk("t6a_fail", a_fail, 1);
    chk("t6a_valid", a_valid, 0); chk("t6a_done", a_done, 0);
    tick;
    chk("t6a_fail_clr", a_fail, 0);

    // T6b: abort in HOLD beats a same-cycle handshake
    sat_mode = 1; a_req = 2; a_start = 1; tick; a_start = 0; tick; tick;
    chk("t6b_valid", a_valid, 1); chk("t6b_data", a_data, 8'h2E);
    a_abort = 1; a_ready = 1; tick; a_abort = 0; a_ready = 0;
    chk("t6b_fail", a_fail, 1); chk("t6b_done", a_done, 0);
    chk("t6b_valid_clr", a_valid, 0); chk("t6b_busy", a_busy, 0);

    // LFSR continues after abort; then reset mid-run in HOLD
    a_req = 1; a_start = 1; tick; a_start = 0; tick;
    chk("t6_cont", a_cand, 8'h17);
    tick;
    chk("t6_hold", a_valid, 1);
    rst = 1; tick; rst = 0;
    chk("mrst_cand", a_cand, 0);   chk("mrst_valid", a_valid, 0);
    chk("mrst_data", a_data, 0);   chk("mrst_busy", a_busy, 0);
    chk("mrst_done", a_done, 0);   chk("mrst_fail", a_fail, 0);
    chk("mrst_tries", a_tries, 0);

    // T4 on the CHECK_LAT=3 instance
    b_seed = 8'h01; b_seed_load = 1; tick; b_seed_load = 0;
    b_req = 3; b_start = 1; b_ready = 1;
    prev = b_cand; ns = 0; done_n = 0; fail_n = 0; last_c = 0;
    for (int c = 0; c < 80 && done_n == 0 && fail_n == 0; c++) begin
      pv = b_valid; pd = b_data; pt = b_tries;
      tick; b_start = 0;
      if (b_cand !== prev) begin last_c = c; prev = b_cand; end
      if (!pv && b_valid) chk("t4_lat", c - last_c, 3);
      if (pv && b_ready) begin
        if (ns < 3) begin
          chk($sformatf("t4_data%0d", ns), pd, exp_draw[ns]);
          chk($sformatf("t4_tries%0d", ns), pt, 1);
        end
        ns++;
      end
      if (b_done) done_n++;
      if (b_fail) fail_n++;
    end
    chk("t4_nsamp", ns, 3); chk("t4_done", done_n, 1);
    chk("t4_fail", fail_n, 0); chk("t4_busy", b_busy, 0);
    b_ready = 0;

    // Randomized runs against a transaction-level prediction
    m_lfsr = 8'h01;
    for (int run = 0; run < 60; run++) begin
      sat_mode = 3;
      case ($urandom_range(0, 3))
        0:       sat_mask = 8'h03;
        1:       sat_mask = 8'h11;
        2:       sat_mask = 8'h81;
        default: sat_mask = 8'h07;
      endcase
      sat_target = 8'($urandom) & sat_mask;
      if ($urandom_range(0, 1) == 1) begin
        a_seed = (run % 7 == 0) ? 8'h00 : 8'($urandom);
        a_seed_load = 1; tick; a_seed_load = 0;
        m_lfsr = (a_seed == 8'h00) ? 8'h01 : a_seed;
      end
      a_req = 16'($urandom_range(0, 3));

      exp_q.delete(); lf = m_lfsr; exp_fail = 0; exp_tries = 0;
      for (int s = 0; s < int'(a_req) && !exp_fail; s++) begin
        t = 0; found = 0;
        while (!found && !exp_fail) begin
          lf = step(lf); t++;
          if (msat(lf)) begin found = 1; exp_q.push_back(lf); end
          else if (t == 4) exp_fail = 1;
        end
        exp_tries = t;
      end

      got_q.delete(); done_n = 0; fail_n = 0; a_start = 1;
      for (int c = 0; c < 200 && done_n + fail_n == 0; c++) begin
        a_ready = ($urandom_range(0, 2) != 0);
        pv = a_valid; pd = a_data;
        tick; a_start = 0;
        if (pv && a_ready) got_q.push_back(pd);
        if (pv && !a_ready) chk("rnd_hold", {a_valid, a_data}, {1'b1, pd});
        if (a_done) done_n++;
        if (a_fail) fail_n++;
      end
      a_ready = 0;
      chk($sformatf("rnd%0d_done", run), done_n, exp_fail ? 0 : 1);
      chk($sformatf("rnd%0d_fail", run), fail_n, exp_fail ? 1 : 0);
      chk($sformatf("rnd%0d_count", run), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        chk($sformatf("rnd%0d_data%0d", run, i), got_q[i], exp_q[i]);
      chk($sformatf("rnd%0d_tries", run), a_tries, exp_tries);
      chk($sformatf("rnd%0d_busy", run), a_busy, 0);
      if (a_req != 0) chk($sformatf("rnd%0d_cand", run), a_cand, lf);
      m_lfsr = lf;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
